// File: rtl/delay_mem_sequencer_if.sv
// SRAM port bundle for the delay-line sequencer.
// master = sequencer side, slave = SRAM macro side.
interface delay_mem_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport master (output sram_csb, output sram_web, output sram_addr,
                    output sram_din, input sram_dout);
    modport slave  (input sram_csb, input sram_web, input sram_addr,
                    input sram_din, output sram_dout);
endinterface

// File: rtl/delay_mem_sequencer.sv
// Delay-line sequencer: per sample tick, reads the sample recorded
// delay_len ticks ago from a circular SRAM buffer, presents it on
// sample_out, then optionally records the new sample and advances the
// write pointer. All outputs are registered.
module delay_mem_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  sample_tick,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  record,
    input  logic                  loop,
    input  logic [ADDR_W-1:0]     delay_len,
    input  logic                  clr_overrun,
    delay_mem_sequencer_if.master sram,
    output logic [DATA_W-1:0]     sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] lat_delay;
    logic [DATA_W-1:0] lat_sample;
    logic              lat_record;
    logic              lat_loop;

    // Sequencer FSM; SRAM strobes are registered on the edge entering RD/WR
    // so they are valid for the whole RD/WR cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            lat_delay      <= '0;
            lat_sample     <= '0;
            lat_record     <= 1'b0;
            lat_loop       <= 1'b0;
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
            sram.sram_csb  <= 1'b1;
            sram.sram_web  <= 1'b1;
            sram.sram_addr <= '0;
            sram.sram_din  <= '0;
        end else begin
            // strobes idle unless a read/write cycle is being entered
            sram.sram_csb <= 1'b1;
            sram.sram_web <= 1'b1;
            sample_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        lat_sample <= sample_in;
                        lat_record <= record;
                        lat_loop   <= loop;
                        lat_delay  <= delay_len;
                        busy       <= 1'b1;
                        state      <= RD;
                        // zero delay is a bypass: no SRAM read at all
                        if (delay_len != '0) begin
                            sram.sram_csb  <= 1'b0;
                            sram.sram_addr <= wr_ptr - delay_len;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    // SRAM read data is valid during CAP
                    sample_out   <= (lat_delay == '0) ? lat_sample : sram.sram_dout;
                    sample_valid <= 1'b1;
                    state        <= WR;
                    if (lat_record) begin
                        sram.sram_csb  <= 1'b0;
                        sram.sram_web  <= 1'b0;
                        sram.sram_addr <= wr_ptr;
                        sram.sram_din  <= lat_sample;
                    end
                end
                WR: begin
                    // record and loop both advance; record+loop acts as record
                    if (lat_record || lat_loop) wr_ptr <= wr_ptr + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a tick arriving while busy is dropped and flagged;
    // setting takes priority over a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                         overrun <= 1'b0;
        else if (sample_tick && state != IDLE) overrun <= 1'b1;
        else if (clr_overrun)                 overrun <= 1'b0;
    end

endmodule

// File: tb/tb_delay_mem_sequencer.sv
// Self-checking bench for delay_mem_sequencer with a behavioural SRAM and
// a reference model of the circular buffer (array + pointer).
module tb_delay_mem_sequencer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              sample_tick;
    logic [DATA_W-1:0] sample_in;
    logic              record;
    logic              loop;
    logic [ADDR_W-1:0] delay_len;
    logic              clr_overrun;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    delay_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    delay_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .sample_tick (sample_tick),
        .sample_in   (sample_in),
        .record      (record),
        .loop        (loop),
        .delay_len   (delay_len),
        .clr_overrun (clr_overrun),
        .sram        (bus.master),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural SRAM: read data appears the cycle after the request
    logic [DATA_W-1:0] mem [DEPTH];
    int wr_count;
    int valid_seen;
    initial begin
        wr_count   = 0;
        valid_seen = 0;
    end
    always @(posedge clk) begin
        if (!bus.sram_csb) begin
            if (!bus.sram_web) begin
                mem[bus.sram_addr] = bus.sram_din;
                wr_count = wr_count + 1;
            end else begin
                bus.sram_dout <= mem[bus.sram_addr];
            end
        end
    end
    always @(negedge clk) if (sample_valid) valid_seen = valid_seen + 1;

    // reference model
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [ADDR_W-1:0] ref_ptr;
    logic              ref_ovr;
    int n_cmp;
    int n_err;

    // One full transaction starting just after a negedge in IDLE.
    // Optionally fires an extra tick during CAP (T+2), with or without clr.
    task automatic run_txn(input logic [DATA_W-1:0] s, input logic rec, input logic lp,
                           input logic [ADDR_W-1:0] dly, input bit ovr_tick, input bit ovr_clr);
        logic [ADDR_W-1:0] exp_raddr;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] exp_out;
        exp_raddr = ref_ptr - dly;
        waddr     = ref_ptr;
        exp_out   = (dly == '0) ? s : ref_mem[exp_raddr];
        sample_tick = 1'b1; sample_in = s; record = rec; loop = lp; delay_len = dly;
        clr_overrun = 1'b0;
        @(negedge clk); // RD; scramble inputs to prove they were latched
        sample_tick = 1'b0; sample_in = DATA_W'($urandom); record = 1'($urandom);
        loop = 1'($urandom); delay_len = ADDR_W'($urandom);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy got %b want 1", busy); end
        n_cmp++; if (bus.sram_csb !== (dly == '0)) begin n_err++; $display("FAIL rd_csb got %b want %b", bus.sram_csb, dly == '0); end
        n_cmp++; if (bus.sram_web !== 1'b1) begin n_err++; $display("FAIL rd_web got %b want 1", bus.sram_web); end
        if (dly != '0) begin
            n_cmp++; if (bus.sram_addr !== exp_raddr) begin n_err++; $display("FAIL rd_addr got %0d want %0d", bus.sram_addr, exp_raddr); end
        end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid got %b want 0", sample_valid); end
        @(negedge clk); // CAP
        n_cmp++; if (bus.sram_csb !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b0) begin
            n_err++; $display("FAIL cap_state csb=%b busy=%b valid=%b want 1 1 0", bus.sram_csb, busy, sample_valid); end
        n_cmp++; if (overrun !== ref_ovr) begin n_err++; $display("FAIL cap_overrun got %b want %b", overrun, ref_ovr); end
        if (ovr_tick) begin
            sample_tick = 1'b1; sample_in = DATA_W'($urandom); clr_overrun = ovr_clr;
            ref_ovr = 1'b1;
        end
        @(negedge clk); // WR
        sample_tick = 1'b0; clr_overrun = 1'b0;
        n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL wr_valid got %b want 1", sample_valid); end
        n_cmp++; if (sample_out !== exp_out) begin n_err++; $display("FAIL wr_sample_out got %h want %h", sample_out, exp_out); end
        n_cmp++; if (bus.sram_csb !== !rec) begin n_err++; $display("FAIL wr_csb got %b want %b", bus.sram_csb, !rec); end
        if (rec) begin
            n_cmp++; if (bus.sram_web !== 1'b0 || bus.sram_addr !== waddr || bus.sram_din !== s) begin
                n_err++; $display("FAIL wr_bus web=%b addr=%0d din=%h want 0 %0d %h", bus.sram_web, bus.sram_addr, bus.sram_din, waddr, s); end
        end
        n_cmp++; if (overrun !== ref_ovr) begin n_err++; $display("FAIL wr_overrun got %b want %b", overrun, ref_ovr); end
        if (rec) ref_mem[waddr] = s;
        if (rec || lp) ref_ptr = ref_ptr + 1'b1;
        @(negedge clk); // IDLE
        n_cmp++; if (busy !== 1'b0 || sample_valid !== 1'b0 || bus.sram_csb !== 1'b1) begin
            n_err++; $display("FAIL idle_state busy=%b valid=%b csb=%b want 0 0 1", busy, sample_valid, bus.sram_csb); end
        n_cmp++; if (sample_out !== exp_out) begin n_err++; $display("FAIL idle_hold got %h want %h", sample_out, exp_out); end
        if (rec) begin
            n_cmp++; if (mem[waddr] !== s) begin n_err++; $display("FAIL mem_content addr %0d got %h want %h", waddr, mem[waddr], s); end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.sram_csb !== 1'b1 || bus.sram_web !== 1'b1 || bus.sram_addr !== '0 || bus.sram_din !== '0) begin
            n_err++; $display("FAIL reset_sram csb=%b web=%b addr=%h din=%h", bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din); end
        n_cmp++; if (sample_out !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL reset_out out=%h valid=%b busy=%b ovr=%b want 0", sample_out, sample_valid, busy, overrun); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        ref_ptr = '0; ref_ovr = 1'b0;
    endtask

    task automatic test_record;
        run_txn(16'h0011, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        run_txn(16'h0022, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        run_txn(16'h0033, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_readback;
        n_cmp++; if (ref_mem[1] !== 16'h0022) begin n_err++; $display("FAIL readback_model got %h want 0022", ref_mem[1]); end
        run_txn(16'h5a5a, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0); // expects addr 1 -> 0x0022
    endtask

    task automatic test_bypass_overrun;
        // record so the write lands at addr 3, confirming the pointer held at 3
        run_txn(16'h8001, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1); // tick at T+2 with clr: set wins
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        ref_ovr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL clr_overrun got %b want 0", overrun); end
    endtask

    task automatic test_wrap;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = '0; ref_ovr = 1'b0;
        for (int i = 0; i < DEPTH; i++) run_txn(DATA_W'($urandom), 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        run_txn(16'h1234, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); // wrapped: writes addr 0, ptr -> 1
        run_txn(16'h0000, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0); // reads addr 254
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] dly;
            dly = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom);
            run_txn(DATA_W'($urandom), 1'($urandom), 1'($urandom), dly,
                    $urandom_range(0, 3) == 0, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                clr_overrun = 1'b1;
                @(negedge clk);
                clr_overrun = 1'b0;
                ref_ovr = 1'b0;
                n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rand_clr got %b want 0", overrun); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int wr0;
        int v0;
        wr0 = wr_count; v0 = valid_seen;
        sample_tick = 1'b1; sample_in = 16'hbeef; record = 1'b1; loop = 1'b0; delay_len = 8'd1;
        @(negedge clk); // RD: extra tick raises overrun
        @(negedge clk); // CAP
        sample_tick = 1'b0;
        n_cmp++; if (busy !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL mid_pre busy=%b ovr=%b want 1 1", busy, overrun); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b0 || sample_out !== '0) begin
            n_err++; $display("FAIL mid_reset_out busy=%b valid=%b ovr=%b out=%h want 0", busy, sample_valid, overrun, sample_out); end
        n_cmp++; if (bus.sram_csb !== 1'b1 || bus.sram_web !== 1'b1 || bus.sram_addr !== '0 || bus.sram_din !== '0) begin
            n_err++; $display("FAIL mid_reset_sram csb=%b web=%b addr=%h din=%h", bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din); end
        @(negedge clk); @(negedge clk);
        n_cmp++; if (wr_count !== wr0 || valid_seen !== v0) begin
            n_err++; $display("FAIL mid_no_side_effect writes=%0d valids=%0d want %0d %0d", wr_count - wr0, valid_seen - v0, 0, 0); end
        rst = 1'b0;
        ref_ptr = '0; ref_ovr = 1'b0;
        run_txn(16'h4321, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); // first tick accepted at once, writes addr 0
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; sample_tick = 1'b0; sample_in = '0; record = 1'b0; loop = 1'b0;
        delay_len = '0; clr_overrun = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DATA_W'($urandom);
            mem[i]     = ref_mem[i];
        end
        test_reset;
        test_record;
        test_readback;
        test_bypass_overrun;
        test_wrap;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
